// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler: key mapping, event layout,
// FSM encodings and the committed-output mapping rule.
package voice_scheduler_pkg;

  localparam int KEY_BASE = 48;
  localparam int NUM_IDS  = 32;
  localparam int ID_W     = 5;
  localparam int KEY_W    = 7;
  localparam int EVT_W    = KEY_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_APPLY      = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_WAIT_ACK   = 3'd4
  } state_t;

  // A held voice plays its own id; a free voice doubles the other held voice (unison).
  function automatic logic [ID_W-1:0] voice_out(
    input logic            own_held,
    input logic [ID_W-1:0] own_id,
    input logic            other_held,
    input logic [ID_W-1:0] other_id,
    input logic [ID_W-1:0] rest_id
  );
    if (own_held)        return own_id;
    else if (other_held) return other_id;
    else                 return rest_id;
  endfunction

endpackage

// File: rtl/voice_scheduler_fifo.sv
// Small synchronous event queue; a push into a full queue is accepted when a pop
// happens in the same cycle.
module note_event_fifo #(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int W         = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [W-1:0]       pop_data,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);

  logic [W-1:0]         mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full     = (count_q == (LOG_DEPTH+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + LOG_DEPTH'(do_push);
    rd_ptr_d = rd_ptr_q + LOG_DEPTH'(do_pop);
    count_d  = count_q + (LOG_DEPTH+1)'(do_push) - (LOG_DEPTH+1)'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler: queues MIDI note events, allocates them to two physics voices with
// oldest-voice stealing, and publishes one coalesced update per video frame.
module voice_scheduler #(
  parameter int KEY_BASE    = voice_scheduler_pkg::KEY_BASE,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOG_DEPTH   = 2,
  parameter int REST_ID     = 0,
  parameter int ACK_TIMEOUT = 2048
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       midi_ready,
  input  logic       note_on,
  input  logic [6:0] note_key,
  input  logic       vsync,
  input  logic       wave_ready,
  output logic [4:0] freq_id1,
  output logic [4:0] freq_id2,
  output logic       new_freq,
  output logic [1:0] voice_active,
  output logic       overflow,
  output logic       busy
);
  import voice_scheduler_pkg::*;

  localparam int ACK_W = $clog2(ACK_TIMEOUT) + 1;

  state_t               state_q, state_d;
  logic                 vsync_q, vsync_rise;
  logic                 fifo_full, fifo_empty, pop_en, more_events;
  logic [EVT_W-1:0]     evt;
  logic [LOG_DEPTH:0]   fifo_count;
  logic [7:0]           id8;
  logic                 id_ok, victim;
  logic [ID_W-1:0]      evt_id;
  logic [1:0]           hit;
  logic [ID_W-1:0]      vid_q [2];
  logic [ID_W-1:0]      vid_d [2];
  logic [1:0]           held_q, held_d;
  logic                 older_q, older_d;
  logic                 changed_q, changed_d;
  logic [ID_W-1:0]      f1_q, f1_d, f2_q, f2_d;
  logic [1:0]           act_q, act_d;
  logic                 nf_q, nf_d, ovf_q, ovf_d;
  logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;

  note_event_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .LOG_DEPTH (LOG_DEPTH),
    .W         (EVT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (midi_ready),
    .push_data ({note_on, note_key}),
    .pop       (pop_en),
    .pop_data  (evt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign vsync_rise   = vsync && !vsync_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign freq_id1     = f1_q;
  assign freq_id2     = f2_q;
  assign new_freq     = nf_q;
  assign voice_active = act_q;
  assign overflow     = ovf_q;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    more_events = (fifo_count > (LOG_DEPTH+1)'(1)) || midi_ready;
    case (state_q)
      ST_IDLE:       if (!fifo_empty) state_d = ST_APPLY;
      ST_APPLY: begin
        if (more_events)    state_d = ST_APPLY;
        else if (changed_d) state_d = ST_WAIT_FRAME;
        else                state_d = ST_IDLE;
      end
      ST_WAIT_FRAME: if (vsync_rise) state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (wave_ready || ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) state_d = ST_IDLE;
      end
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_en    = (state_q == ST_APPLY);
    // 8-bit difference: keys below KEY_BASE wrap high and fail the range test
    id8       = {1'b0, evt[KEY_W-1:0]} - 8'(KEY_BASE);
    id_ok     = (id8 < 8'(NUM_IDS));
    evt_id    = id8[ID_W-1:0];
    hit[0]    = held_q[0] && (vid_q[0] == evt_id);
    hit[1]    = held_q[1] && (vid_q[1] == evt_id);
    victim    = !held_q[0] ? 1'b0 : (!held_q[1] ? 1'b1 : older_q);

    held_d    = held_q;
    vid_d     = vid_q;
    older_d   = older_q;
    changed_d = changed_q;
    if (pop_en && id_ok) begin
      if (evt[EVT_W-1]) begin
        if (hit == 2'b00) begin
          vid_d[victim]  = evt_id;
          held_d[victim] = 1'b1;
          older_d        = ~victim;
          changed_d      = 1'b1;
        end
      end else if (hit != 2'b00) begin
        held_d    = held_q & ~hit;
        changed_d = 1'b1;
      end
    end
    if (state_q == ST_ISSUE) changed_d = 1'b0;

    f1_d  = f1_q;
    f2_d  = f2_q;
    act_d = act_q;
    nf_d  = (state_q == ST_ISSUE);
    if (state_q == ST_ISSUE) begin
      f1_d  = voice_out(held_q[0], vid_q[0], held_q[1], vid_q[1], ID_W'(REST_ID));
      f2_d  = voice_out(held_q[1], vid_q[1], held_q[0], vid_q[0], ID_W'(REST_ID));
      act_d = held_q;
    end

    ovf_d     = ovf_q | (midi_ready & fifo_full & ~pop_en);
    ack_cnt_d = (state_q == ST_WAIT_ACK) ? ack_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vsync_q   <= 1'b0;
      vid_q[0]  <= '0;
      vid_q[1]  <= '0;
      held_q    <= '0;
      older_q   <= 1'b0;
      changed_q <= 1'b0;
      f1_q      <= ID_W'(REST_ID);
      f2_q      <= ID_W'(REST_ID);
      act_q     <= '0;
      nf_q      <= 1'b0;
      ovf_q     <= 1'b0;
      ack_cnt_q <= '0;
    end else begin
      vsync_q   <= vsync;
      vid_q     <= vid_d;
      held_q    <= held_d;
      older_q   <= older_d;
      changed_q <= changed_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      act_q     <= act_d;
      nf_q      <= nf_d;
      ovf_q     <= ovf_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: frame-structured random note traffic checked every cycle
// against an event-list model of voice allocation, plus directed literal cases.
`timescale 1ns/1ps
module tb_voice_scheduler;

  localparam int KB    = 48;
  localparam int DEPTH = 4;
  localparam int TOUT  = 2048;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       midi_ready = 1'b0;
  logic       note_on = 1'b0;
  logic [6:0] note_key = '0;
  logic       vsync = 1'b0;
  logic       wave_ready = 1'b0;
  logic [4:0] freq_id1, freq_id2;
  logic       new_freq;
  logic [1:0] voice_active;
  logic       overflow, busy;

  always #5 clock = ~clock;

  voice_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .midi_ready   (midi_ready),
    .note_on      (note_on),
    .note_key     (note_key),
    .vsync        (vsync),
    .wave_ready   (wave_ready),
    .freq_id1     (freq_id1),
    .freq_id2     (freq_id2),
    .new_freq     (new_freq),
    .voice_active (voice_active),
    .overflow     (overflow),
    .busy         (busy)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // expected outputs
  logic [4:0] exp_f1, exp_f2;
  logic [1:0] exp_act;
  logic       exp_nf, exp_ovf;

  // model: pending events, and per voice held/id/assignment time
  logic [7:0] mq[$];
  logic [7:0] stim[$];
  bit m_held[2];
  int m_id[2];
  int m_stamp[2];
  int m_age;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    if (!chk_en) return;
    tests++;
    if ({freq_id1, freq_id2, voice_active, new_freq, overflow} !==
        {exp_f1, exp_f2, exp_act, exp_nf, exp_ovf}) begin
      fails++;
      $display("FAIL cycle t=%0t got f1=%0d f2=%0d act=%b nf=%b ovf=%b expected f1=%0d f2=%0d act=%b nf=%b ovf=%b",
               $time, freq_id1, freq_id2, voice_active, new_freq, overflow,
               exp_f1, exp_f2, exp_act, exp_nf, exp_ovf);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cmp_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    exp_f1 = 0; exp_f2 = 0; exp_act = 0; exp_nf = 0; exp_ovf = 0;
    mq.delete();
    for (int i = 0; i < 2; i++) begin
      m_held[i] = 0; m_id[i] = 0; m_stamp[i] = 0;
    end
    m_age = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      model_clear();
      chk_en = 1;
    end
    reset = 1'b1;
  endtask

  // Apply all pending events in arrival order; report whether anything changed.
  task automatic model_apply(output bit ch);
    logic [7:0] e;
    int id, v;
    ch = 0;
    while (mq.size() > 0) begin
      e  = mq.pop_front();
      id = int'(e[6:0]) - KB;
      if (id < 0 || id > 31) continue;
      if (e[7]) begin
        if ((m_held[0] && m_id[0] == id) || (m_held[1] && m_id[1] == id)) continue;
        if (!m_held[0])      v = 0;
        else if (!m_held[1]) v = 1;
        else                 v = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
        m_age++;
        m_held[v] = 1; m_id[v] = id; m_stamp[v] = m_age;
        ch = 1;
      end else begin
        for (int i = 0; i < 2; i++)
          if (m_held[i] && m_id[i] == id) begin
            m_held[i] = 0;
            ch = 1;
          end
      end
    end
  endtask

  task automatic push_evt(input logic [7:0] e, input bit in_ack);
    midi_ready = 1'b1;
    note_on    = e[7];
    note_key   = e[6:0];
    tick();
    midi_ready = 1'b0;
    if (in_ack && mq.size() >= DEPTH) exp_ovf = 1;
    else mq.push_back(e);
  endtask

  task automatic send_burst();
    while (stim.size() > 0) push_evt(stim.pop_front(), 0);
    repeat (8) tick();
  endtask

  task automatic do_vsync(output bit issued);
    bit ch;
    vsync = 1'b1;
    model_apply(ch);
    tick();
    tick();
    if (ch) begin
      exp_nf  = 1;
      exp_f1  = m_held[0] ? 5'(m_id[0]) : (m_held[1] ? 5'(m_id[1]) : 5'd0);
      exp_f2  = m_held[1] ? 5'(m_id[1]) : (m_held[0] ? 5'(m_id[0]) : 5'd0);
      exp_act = {m_held[1] ? 1'b1 : 1'b0, m_held[0] ? 1'b1 : 1'b0};
    end
    tick();
    exp_nf = 0;
    vsync  = 1'b0;
    issued = ch;
  endtask

  // Optionally load stim events while the DUT waits for the ack, then ack.
  task automatic ack_phase(input bit issued);
    bit loaded;
    loaded = 0;
    if (issued) begin
      check("busy_wait_ack", 32'(busy), 1);
      while (stim.size() > 0) begin
        push_evt(stim.pop_front(), 1);
        loaded = 1;
      end
    end
    stim.delete();
    wave_ready = 1'b1;
    tick();
    wave_ready = 1'b0;
    repeat (8) tick();
    if (!loaded) check("busy_settled", 32'(busy), 0);
  endtask

  function automatic logic [7:0] rand_evt();
    logic [6:0] k;
    logic       on;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      k = 7'($urandom_range(0, 47));
    else if (r == 1) k = 7'($urandom_range(80, 127));
    else             k = 7'(KB + $urandom_range(0, 5));
    on = ($urandom_range(0, 2) != 0);
    return {on, k};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit iss;
    bit preloaded;
    int n, k;

    // reset state
    do_reset(3);
    repeat (4) tick();
    check("rst_f1", 32'(freq_id1), 0);
    check("rst_f2", 32'(freq_id2), 0);
    check("rst_nf", 32'(new_freq), 0);
    check("rst_act", 32'(voice_active), 0);
    check("rst_busy", 32'(busy), 0);

    // single note -> unison
    stim.push_back({1'b1, 7'd60});
    send_burst();
    do_vsync(iss);
    check("t2_f1", 32'(freq_id1), 12);
    check("t2_f2", 32'(freq_id2), 12);
    check("t2_act", 32'(voice_active), 1);
    ack_phase(iss);

    // release 60, then three notes; the first of them is stolen
    stim.push_back({1'b0, 7'd60});
    stim.push_back({1'b1, 7'd50});
    stim.push_back({1'b1, 7'd55});
    stim.push_back({1'b1, 7'd57});
    send_burst();
    do_vsync(iss);
    check("t3_f1", 32'(freq_id1), 9);
    check("t3_f2", 32'(freq_id2), 7);
    check("t3_act", 32'(voice_active), 3);
    ack_phase(iss);

    // out-of-range keys and unheld note-off: no update
    stim.push_back({1'b1, 7'd47});
    stim.push_back({1'b1, 7'd80});
    stim.push_back({1'b0, 7'd70});
    send_burst();
    do_vsync(iss);
    check("t4_f1", 32'(freq_id1), 9);
    check("t4_f2", 32'(freq_id2), 7);
    ack_phase(iss);

    // overflow: 6 events while waiting for ack, only the first 4 survive
    stim.push_back({1'b1, 7'd52});
    send_burst();
    do_vsync(iss);
    check("t5_pre_f1", 32'(freq_id1), 9);
    check("t5_pre_f2", 32'(freq_id2), 4);
    stim.push_back({1'b0, 7'd57});
    stim.push_back({1'b0, 7'd52});
    stim.push_back({1'b1, 7'd60});
    stim.push_back({1'b1, 7'd61});
    stim.push_back({1'b1, 7'd62});
    stim.push_back({1'b1, 7'd63});
    ack_phase(iss);
    check("t5_ovf", 32'(overflow), 1);
    do_vsync(iss);
    check("t5_f1", 32'(freq_id1), 12);
    check("t5_f2", 32'(freq_id2), 13);
    check("t5_act", 32'(voice_active), 3);
    ack_phase(iss);

    // random frames
    preloaded = 0;
    for (int f = 0; f < 120; f++) begin
      if (!preloaded) begin
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) stim.push_back(rand_evt());
        send_burst();
      end
      do_vsync(iss);
      k = iss ? $urandom_range(0, 6) : 0;
      for (int i = 0; i < k; i++) stim.push_back(rand_evt());
      ack_phase(iss);
      preloaded = (k > 0);
    end
    if (preloaded) begin
      do_vsync(iss);
      ack_phase(iss);
    end

    // ack timeout: on/off of one key in a frame still issues, then no wave_ready
    stim.push_back({1'b1, 7'd65});
    stim.push_back({1'b0, 7'd65});
    send_burst();
    do_vsync(iss);
    repeat (TOUT - 2) tick();
    check("timeout_busy_before", 32'(busy), 1);
    tick();
    check("timeout_busy_after", 32'(busy), 0);

    // reset while waiting for a frame cancels the pending update
    stim.push_back({1'b1, 7'd60});
    send_burst();
    do_reset(2);
    repeat (3) tick();
    do_vsync(iss);
    check("rst_mid_f1", 32'(freq_id1), 0);
    check("rst_mid_f2", 32'(freq_id2), 0);
    check("rst_mid_act", 32'(voice_active), 0);
    check("rst_mid_ovf", 32'(overflow), 0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
